// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS pipeline stages.
// Holds the widths, NOP encoding, PC increment and the fetch FSM state type.
package mips_pkg;

    localparam int PC_W    = 32;
    localparam int INSTR_W = 32;
    localparam int PC_INC  = 4;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } if_state_t;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register with load, hold and clear controls.
// Clear wins over load; clear drops valid and the instruction but keeps pc4.
module ifid_reg
    import mips_pkg::*;
#(
    parameter int PC_W    = mips_pkg::PC_W,
    parameter int INSTR_W = mips_pkg::INSTR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               clear,
    input  logic [INSTR_W-1:0] instr_d,
    input  logic [PC_W-1:0]    pc4_d,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    pc4,
    output logic               valid
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr <= INSTR_W'(NOP_INSTR);
            pc4   <= '0;
            valid <= 1'b0;
        end else if (clear) begin
            instr <= INSTR_W'(NOP_INSTR);
            valid <= 1'b0;
        end else if (load) begin
            instr <= instr_d;
            pc4   <= pc4_d;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: program counter, boot/run FSM, IF/ID loading.
// Redirect beats flush beats stall; a fetch completes only when imem_ready is high.
module if_stage
    import mips_pkg::*;
#(
    parameter int PC_W    = mips_pkg::PC_W,
    parameter int INSTR_W = mips_pkg::INSTR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PC_W-1:0]    start_pc,
    input  logic               stall,
    input  logic               flush,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_ready,
    output logic [PC_W-1:0]    pc,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [PC_W-1:0]    ifid_pc4,
    output logic               ifid_valid,
    output logic [31:0]        fetch_cnt,
    output logic [31:0]        bubble_cnt,
    output if_state_t          fsm_state
);

    // Memory handshake: imem_addr is presented every cycle; the word on
    // imem_rdata is consumed on an edge only when imem_ready is high in that
    // cycle and the stage is neither stalled, flushed nor redirected.

    if_state_t       state, state_next;
    logic [PC_W-1:0] pc_next;
    logic [PC_W-1:0] pc_plus4;
    logic            ifid_load;
    logic            ifid_clear;
    logic            fetch_inc;
    logic            bubble_inc;

    assign pc_plus4  = pc + PC_W'(PC_INC);
    assign imem_addr = pc;
    assign fsm_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= BOOT;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            BOOT:    state_next = RUN;
            RUN:     state_next = RUN;
            default: state_next = BOOT;
        endcase
    end

    always_comb begin
        pc_next    = pc;
        ifid_load  = 1'b0;
        ifid_clear = 1'b0;
        fetch_inc  = 1'b0;
        bubble_inc = 1'b0;
        case (state)
            BOOT: begin
                pc_next = {start_pc[PC_W-1:2], 2'b00};
            end
            RUN: begin
                if (redirect) begin
                    pc_next    = {redirect_pc[PC_W-1:2], 2'b00};
                    ifid_clear = 1'b1;
                    bubble_inc = 1'b1;
                end else if (flush) begin
                    // The fetched word is discarded but the PC still advances.
                    if (!stall && imem_ready) pc_next = pc_plus4;
                    ifid_clear = 1'b1;
                    bubble_inc = 1'b1;
                end else if (stall) begin
                    pc_next = pc;
                end else if (imem_ready) begin
                    pc_next   = pc_plus4;
                    ifid_load = 1'b1;
                    fetch_inc = 1'b1;
                end else begin
                    ifid_clear = 1'b1;
                    bubble_inc = 1'b1;
                end
            end
            default: pc_next = pc;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc         <= '0;
            fetch_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            pc <= pc_next;
            if (fetch_inc)  fetch_cnt  <= fetch_cnt + 32'd1;
            if (bubble_inc) bubble_cnt <= bubble_cnt + 32'd1;
        end
    end

    ifid_reg #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W)
    ) u_ifid (
        .clk     (clk),
        .rst     (rst),
        .load    (ifid_load),
        .clear   (ifid_clear),
        .instr_d (imem_rdata),
        .pc4_d   (pc_plus4),
        .instr   (ifid_instr),
        .pc4     (ifid_pc4),
        .valid   (ifid_valid)
    );

endmodule
